// File: rtl/channel_mux_rr_pkg.sv
// Shared definitions for channel_mux_rr.
//   MODE_FIXED / MODE_RR : encodings of the mode input.
//   out_state_e          : output-stage state (ST_EMPTY / ST_FULL).
//   rr_next              : advance a round-robin pointer by one, with wrap.
package channel_mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Pointer following the channel idx; N_CH-1 wraps back to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/channel_mux_rr_pick.sv
// rr_priority_pick: combinational rotating priority encoder.
//   req       : request vector, one bit per channel
//   ptr       : highest-priority channel this cycle
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted channel (0 when no request)
//   grant_vld : some request was granted
// Priority order is ptr, ptr+1, ... mod N_CH.
module rr_priority_pick #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int         idx;
    logic [SEL_W-1:0] sidx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    sidx      = '0;
    // Scan from the lowest-priority offset up so the closest request to ptr
    // is the last one written and therefore wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      sidx = SEL_W'(idx);
      if (req[sidx]) begin
        grant       = '0;
        grant[sidx] = 1'b1;
        grant_idx   = sidx;
        grant_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_mux_rr.sv
// channel_mux_rr: N_CH-channel selector with a registered output stage and
// valid/ready handshake. FIXED mode passes channel sel; ROUND-ROBIN mode
// rotates a fair grant starting at ptr.
//   clk, rst_n        : clock, async active-low reset
//   in_valid/in_ready : per-channel handshake (in_ready is combinational)
//   in_data           : channel i at [i*DATA_W +: DATA_W]
//   mode, sel         : 0 = FIXED (uses sel), 1 = ROUND-ROBIN
//   out_valid/out_ready, out_data, out_ch : registered output word + source id
//   out_parity        : even parity of out_data, only with MUX_PARITY_EN defined
module channel_mux_rr
  import channel_mux_rr_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch
`ifdef MUX_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  logic [N_CH-1:0][DATA_W-1:0] in_words;
  logic [N_CH-1:0]             rr_grant, grant;
  logic [SEL_W-1:0]            rr_idx, xfer_idx, ptr, ptr_nxt;
  logic                        rr_vld, can_load, xfer;
  out_state_e                  state, state_nxt;

  assign in_words = in_data;

  rr_priority_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_vld (rr_vld)
  );

  // Grant mux. Grants are always a subset of in_valid, so any grant bit that
  // survives can_load is a transfer.
  always_comb begin
    grant    = '0;
    xfer_idx = sel;
    if (mode == MODE_RR) begin
      grant    = rr_grant;
      xfer_idx = rr_idx;
    end else if (int'(sel) < N_CH) begin
      grant[sel] = in_valid[sel];
    end
  end

  assign can_load = !out_valid || out_ready;
  assign in_ready = can_load ? grant : '0;
  assign xfer     = can_load && (|grant);
  assign ptr_nxt  = SEL_W'(rr_next(int'(rr_idx), N_CH));

  // Output-stage FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Output-stage FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (xfer) state_nxt = ST_FULL;
      ST_FULL:  if (xfer) state_nxt = ST_FULL;
                else if (out_ready) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Output-stage FSM: outputs
  always_comb begin
    out_valid = (state == ST_FULL);
  end

  // Output word register; held whenever there is no transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if (xfer) begin
      out_data <= in_words[xfer_idx];
      out_ch   <= xfer_idx;
    end
  end

`ifdef MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    out_parity <= 1'b0;
    else if (xfer) out_parity <= ^in_words[xfer_idx];
  end
`endif

  // ptr only moves on round-robin transfers, so FIXED periods leave it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ptr <= '0;
    else if (xfer && mode == MODE_RR) ptr <= ptr_nxt;
  end

  logic unused_ok;
  assign unused_ok = rr_vld;

endmodule
